// File: rtl/commit_trace_pkg.sv
`default_nettype none
// ============================================================================
// commit_trace_pkg : record layout, flag positions and state encodings shared
//                    by the commit trace recorder.
// Revision: 1.0
// ============================================================================
package commit_trace_pkg;

  localparam int FLAG_REGWRITE = 0;
  localparam int FLAG_MEMREAD  = 1;
  localparam int FLAG_MEMWRITE = 2;
  localparam int FLAG_HALT     = 3;

  localparam int REC_W = 87;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  typedef struct packed {
    logic [15:0] inum;
    logic [15:0] pc;
    logic [15:0] wdata;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic [2:0]  wreg;
    logic [3:0]  flags;
  } trace_rec_t;

  function automatic logic [3:0] pack_flags(input logic halt, input logic memwrite,
                                            input logic memread, input logic regwrite);
    logic [3:0] f;
    f                = '0;
    f[FLAG_HALT]     = halt;
    f[FLAG_MEMWRITE] = memwrite;
    f[FLAG_MEMREAD]  = memread;
    f[FLAG_REGWRITE] = regwrite;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo_mem.sv
`default_nettype none
// ============================================================================
// trace_fifo_mem : DEPTH x WIDTH register array, one write port and an
//                  asynchronous read port. No control logic.
// Revision: 1.0
// ============================================================================
module trace_fifo_mem
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int WIDTH = REC_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// commit_trace_fifo : records one stamped trace record per retired instruction,
//                     buffers it and drains it over valid/ready; done after halt.
// Revision: 1.0
// ============================================================================
module commit_trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [15:0] c_pc,
  input  logic        c_regwrite,
  input  logic [2:0]  c_wreg,
  input  logic [15:0] c_wdata,
  input  logic        c_memread,
  input  logic        c_memwrite,
  input  logic [15:0] c_maddr,
  input  logic [15:0] c_mdata,
  input  logic        c_halt,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [15:0] rec_inum,
  output logic [15:0] rec_pc,
  output logic [15:0] rec_wdata,
  output logic [15:0] rec_maddr,
  output logic [15:0] rec_mdata,
  output logic [2:0]  rec_wreg,
  output logic [3:0]  rec_flags,
  output logic        almost_full,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic [31:0] cycle_cnt,
  output logic        done
);

  localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   AF_LEVEL   = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [15:0]       inum_q, inum_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic              done_q, done_d;

  logic              full, pop, push, drop, commit_run;
  trace_rec_t        new_rec, head_rec;
  logic [REC_W-1:0]  head_bits;

  assign full       = (count_q == FULL_LEVEL);
  assign rec_valid  = (count_q != '0);
  assign pop        = rec_valid & rec_ready;
  assign commit_run = commit_valid & (state_q == ST_RUN);
  // A full FIFO still takes a commit when the head leaves in the same cycle.
  assign push       = commit_run & (~full | pop);
  assign drop       = commit_run & ~push;

  always_comb begin
    new_rec       = '0;
    new_rec.inum  = inum_q;
    new_rec.pc    = c_pc;
    new_rec.wdata = c_wdata;
    new_rec.maddr = c_maddr;
    new_rec.mdata = c_mdata;
    new_rec.wreg  = c_wreg;
    new_rec.flags = pack_flags(c_halt, c_memwrite, c_memread, c_regwrite);
  end

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (REC_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (new_rec),
    .raddr (rd_ptr_q),
    .rdata (head_bits)
  );

  assign head_rec = trace_rec_t'(head_bits);

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    if (pop && !push) count_d = count_q - CNT_ONE;
    inum_d      = commit_run ? inum_q + 16'd1 : inum_q;
    overflow_d  = overflow_q | drop;
    drop_cnt_d  = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    cycle_cnt_d = cycle_cnt_q + 32'd1;

    state_d = state_q;
    case (state_q)
      ST_RUN:    if (commit_run && c_halt) state_d = ST_HALTED;
      ST_HALTED: if (count_d == '0)        state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_RUN;
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inum_q      <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inum_q      <= inum_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
    end
  end

  assign rec_inum    = head_rec.inum;
  assign rec_pc      = head_rec.pc;
  assign rec_wdata   = head_rec.wdata;
  assign rec_maddr   = head_rec.maddr;
  assign rec_mdata   = head_rec.mdata;
  assign rec_wreg    = head_rec.wreg;
  assign rec_flags   = head_rec.flags;
  assign almost_full = (count_q >= AF_LEVEL);
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// tb_commit_trace_fifo : directed scenarios plus randomized traffic checked
//                        against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_commit_trace_fifo;
  import commit_trace_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid, c_regwrite, c_memread, c_memwrite, c_halt, rec_ready;
  logic [15:0] c_pc, c_wdata, c_maddr, c_mdata;
  logic [2:0]  c_wreg;
  logic        rec_valid, almost_full, overflow, done;
  logic [15:0] rec_inum, rec_pc, rec_wdata, rec_maddr, rec_mdata;
  logic [2:0]  rec_wreg;
  logic [3:0]  rec_flags;
  logic [7:0]  drop_cnt;
  logic [31:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  trace_rec_t  mq[$];
  int          m_inum, m_drops;
  bit          m_ovf, m_halted, m_done;
  logic [31:0] m_cycles;

  commit_trace_fifo #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .c_pc(c_pc),
    .c_regwrite(c_regwrite), .c_wreg(c_wreg), .c_wdata(c_wdata),
    .c_memread(c_memread), .c_memwrite(c_memwrite), .c_maddr(c_maddr),
    .c_mdata(c_mdata), .c_halt(c_halt), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_inum(rec_inum), .rec_pc(rec_pc),
    .rec_wdata(rec_wdata), .rec_maddr(rec_maddr), .rec_mdata(rec_mdata),
    .rec_wreg(rec_wreg), .rec_flags(rec_flags), .almost_full(almost_full),
    .overflow(overflow), .drop_cnt(drop_cnt), .cycle_cnt(cycle_cnt), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    commit_valid = 0; c_pc = 0; c_regwrite = 0; c_wreg = 0; c_wdata = 0;
    c_memread = 0; c_memwrite = 0; c_maddr = 0; c_mdata = 0; c_halt = 0;
  endtask

  task automatic set_commit(input logic [15:0] pc, input logic rw, input logic [2:0] wreg,
                            input logic [15:0] wdata, input logic mr, input logic mw,
                            input logic [15:0] maddr, input logic [15:0] mdata,
                            input logic halt);
    commit_valid = 1; c_pc = pc; c_regwrite = rw; c_wreg = wreg; c_wdata = wdata;
    c_memread = mr; c_memwrite = mw; c_maddr = maddr; c_mdata = mdata; c_halt = halt;
  endtask

  task automatic model_clear();
    mq.delete();
    m_inum = 0; m_drops = 0; m_ovf = 0; m_halted = 0; m_done = 0; m_cycles = 0;
  endtask

  // Applies the effect of the coming clock edge to the model.
  task automatic model_step();
    bit was_halted;
    trace_rec_t r;
    was_halted = m_halted;
    if (mq.size() > 0 && rec_ready) void'(mq.pop_front());
    if (commit_valid && !m_halted) begin
      if (mq.size() < DEPTH) begin
        r.inum = 16'(m_inum); r.pc = c_pc; r.wdata = c_wdata; r.maddr = c_maddr;
        r.mdata = c_mdata; r.wreg = c_wreg;
        r.flags = {c_halt, c_memwrite, c_memread, c_regwrite};
        mq.push_back(r);
      end else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
      m_inum = (m_inum + 1) % 65536;
      if (c_halt) m_halted = 1;
    end
    if (was_halted && mq.size() == 0) m_done = 1;
    m_cycles = m_cycles + 32'd1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0; rec_ready = 0; idle_inputs(); model_clear();
    @(negedge clk); @(negedge clk);
    rst = 1;
    tick();
  endtask

  task automatic test_reset();
    rst = 0; rec_ready = 0; idle_inputs(); model_clear();
    #2;
    n_checks++;
    if ({rec_valid, almost_full, overflow, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {rec_valid, almost_full, overflow, done});
    end
    n_checks++;
    if ({drop_cnt, cycle_cnt} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got drop=%0d cyc=%0d want 0 0", drop_cnt, cycle_cnt);
    end
    @(negedge clk);
    rst = 1;
    tick();
    n_checks++;
    if (cycle_cnt !== 32'd1 || rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got cyc=%0d valid=%b want 1 0", cycle_cnt, rec_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    rec_ready = 1;
    set_commit(16'h0000, 1, 3'd3, 16'h1234, 0, 0, 16'h0, 16'h0, 0);
    #1;
    n_checks++;
    if (rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_bypass: got valid=%b want 0", rec_valid);
    end
    tick();
    idle_inputs();
    n_checks++;
    if ({rec_valid, rec_inum, rec_flags} !== {1'b1, 16'h0000, 4'b0001}) begin
      n_fail++;
      $display("FAIL single_head: got v=%b inum=%h fl=%b want 1 0000 0001",
               rec_valid, rec_inum, rec_flags);
    end
    n_checks++;
    if ({rec_wreg, rec_wdata, rec_pc} !== {3'd3, 16'h1234, 16'h0000}) begin
      n_fail++;
      $display("FAIL single_fields: got wreg=%0d wdata=%h pc=%h want 3 1234 0000",
               rec_wreg, rec_wdata, rec_pc);
    end
    tick();
    n_checks++;
    if ({rec_valid, almost_full, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_drained: got %b want 000", {rec_valid, almost_full, done});
    end
  endtask

  task automatic test_fill();
    logic [7:0]  exp_drop;
    logic [15:0] exp_inum;
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 10; i++) begin
      set_commit(16'(i), 1, 3'(i), 16'(i * 7), 0, 0, 16'h0, 16'h0, 0);
      tick();
      exp_drop = (i + 1 > DEPTH) ? 8'(i + 1 - DEPTH) : 8'd0;
      n_checks++;
      if ({almost_full, overflow, drop_cnt} !== {(i + 1 >= DEPTH - 1), (i + 1 > DEPTH), exp_drop}) begin
        n_fail++;
        $display("FAIL fill_commit%0d: got af=%b ovf=%b drop=%0d want %b %b %0d", i + 1,
                 almost_full, overflow, drop_cnt, (i + 1 >= DEPTH - 1), (i + 1 > DEPTH), exp_drop);
      end
    end
    idle_inputs();
    rec_ready = 1;
    for (int j = 0; j < DEPTH; j++) begin
      exp_inum = 16'(j);
      n_checks++;
      if ({rec_valid, rec_inum, rec_pc} !== {1'b1, exp_inum, exp_inum}) begin
        n_fail++;
        $display("FAIL fill_drain%0d: got v=%b inum=%0d pc=%0d want 1 %0d %0d", j,
                 rec_valid, rec_inum, rec_pc, exp_inum, exp_inum);
      end
      tick();
    end
    n_checks++;
    if (rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_empty: got valid=%b want 0", rec_valid);
    end
  endtask

  task automatic test_full_push_pop();
    int          popped;
    logic [15:0] last_inum, last_pc;
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      set_commit(16'h0100 + 16'(i), 1, 3'd1, 16'(i), 0, 0, 16'h0, 16'h0, 0);
      tick();
    end
    rec_ready = 1;
    set_commit(16'h0200, 1, 3'd2, 16'h5555, 0, 0, 16'h0, 16'h0, 0);
    tick();
    n_checks++;
    if ({rec_valid, rec_inum, overflow, drop_cnt, almost_full} !== {1'b1, 16'd1, 1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL fullpp_head: got v=%b inum=%0d ovf=%b drop=%0d af=%b want 1 1 0 0 1",
               rec_valid, rec_inum, overflow, drop_cnt, almost_full);
    end
    rec_ready = 0;
    set_commit(16'h0300, 1, 3'd3, 16'h6666, 0, 0, 16'h0, 16'h0, 0);
    tick();
    n_checks++;
    if (drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL fullpp_still_full: got drop=%0d want 1", drop_cnt);
    end
    idle_inputs();
    rec_ready = 1;
    popped = 0; last_inum = 'x; last_pc = 'x;
    for (int k = 0; k < 20 && rec_valid === 1'b1; k++) begin
      last_inum = rec_inum; last_pc = rec_pc; popped++;
      tick();
    end
    n_checks++;
    if (popped != DEPTH || {last_inum, last_pc} !== {16'd8, 16'h0200}) begin
      n_fail++;
      $display("FAIL fullpp_drain: got n=%0d inum=%0d pc=%h want 8 8 0200", popped, last_inum, last_pc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    rec_ready = 1;
    set_commit(16'h0000, 0, 3'd0, 16'h0, 0, 1, 16'h0040, 16'hBEEF, 0);
    tick();
    n_checks++;
    if ({rec_valid, rec_inum, rec_flags, rec_maddr, rec_mdata} !==
        {1'b1, 16'd0, 4'b0100, 16'h0040, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL halt_store: got v=%b inum=%0d fl=%b a=%h d=%h want 1 0 0100 0040 beef",
               rec_valid, rec_inum, rec_flags, rec_maddr, rec_mdata);
    end
    set_commit(16'h0002, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    tick();
    n_checks++;
    if ({rec_valid, rec_inum, rec_flags, rec_pc, done} !== {1'b1, 16'd1, 4'b1000, 16'h0002, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_record: got v=%b inum=%0d fl=%b pc=%h done=%b want 1 1 1000 0002 0",
               rec_valid, rec_inum, rec_flags, rec_pc, done);
    end
    for (int i = 0; i < 3; i++) begin
      set_commit(16'h0010 + 16'(i), 1, 3'd5, 16'hAAAA, 0, 0, 16'h0, 16'h0, 0);
      tick();
      n_checks++;
      if ({rec_valid, done, drop_cnt} !== {1'b0, 1'b1, 8'd0}) begin
        n_fail++;
        $display("FAIL halt_after%0d: got v=%b done=%b drop=%0d want 0 1 0", i,
                 rec_valid, done, drop_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 10; i++) begin
      set_commit(16'h0400 + 16'(i), 1, 3'd4, 16'(i), 0, 0, 16'h0, 16'h0, 0);
      tick();
    end
    idle_inputs();
    rec_ready = 1;
    repeat (4) tick();
    rec_ready = 0;
    n_checks++;
    if ({rec_valid, overflow, rec_inum} !== {1'b1, 1'b1, 16'd4}) begin
      n_fail++;
      $display("FAIL midrst_pre: got v=%b ovf=%b inum=%0d want 1 1 4", rec_valid, overflow, rec_inum);
    end
    #2;
    rst = 0;
    #1;
    n_checks++;
    if ({rec_valid, overflow, done, almost_full, drop_cnt, cycle_cnt} !== 44'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b ovf=%b done=%b af=%b drop=%0d cyc=%0d want all 0",
               rec_valid, overflow, done, almost_full, drop_cnt, cycle_cnt);
    end
    model_clear();
    @(negedge clk);
    rst = 1;
    tick();
    set_commit(16'h0777, 1, 3'd7, 16'h0abc, 0, 0, 16'h0, 16'h0, 0);
    tick();
    idle_inputs();
    n_checks++;
    if ({rec_valid, rec_inum, rec_pc} !== {1'b1, 16'd0, 16'h0777}) begin
      n_fail++;
      $display("FAIL midrst_inum: got v=%b inum=%0d pc=%h want 1 0 0777", rec_valid, rec_inum, rec_pc);
    end
  endtask

  task automatic test_random();
    int ready_pct;
    trace_rec_t got;
    for (int rnd = 0; rnd < 4; rnd++) begin
      do_reset();
      ready_pct = 15 + rnd * 25;
      for (int cyc = 0; cyc < 150; cyc++) begin
        commit_valid = ($urandom_range(0, 99) < 60);
        c_pc = 16'($urandom); c_wdata = 16'($urandom); c_maddr = 16'($urandom);
        c_mdata = 16'($urandom); c_wreg = 3'($urandom);
        c_regwrite = 1'($urandom); c_memread = 1'($urandom); c_memwrite = 1'($urandom);
        c_halt = ($urandom_range(0, 149) == 0);
        rec_ready = ($urandom_range(0, 99) < ready_pct);
        tick();
        got = {rec_inum, rec_pc, rec_wdata, rec_maddr, rec_mdata, rec_wreg, rec_flags};
        n_checks++;
        if (rec_valid !== (mq.size() > 0)) begin
          n_fail++;
          $display("FAIL rand_valid r%0d c%0d: got %b want %b", rnd, cyc, rec_valid, (mq.size() > 0));
        end
        if (mq.size() > 0) begin
          n_checks++;
          if (got !== mq[0]) begin
            n_fail++;
            $display("FAIL rand_head r%0d c%0d: got %h want %h", rnd, cyc, got, mq[0]);
          end
        end
        n_checks++;
        if ({almost_full, overflow, drop_cnt, done} !==
            {(mq.size() >= DEPTH - 1), m_ovf, 8'(m_drops), m_done}) begin
          n_fail++;
          $display("FAIL rand_status r%0d c%0d: got af=%b ovf=%b drop=%0d done=%b want %b %b %0d %b",
                   rnd, cyc, almost_full, overflow, drop_cnt, done,
                   (mq.size() >= DEPTH - 1), m_ovf, m_drops, m_done);
        end
        n_checks++;
        if (cycle_cnt !== m_cycles) begin
          n_fail++;
          $display("FAIL rand_cycles r%0d c%0d: got %0d want %0d", rnd, cyc, cycle_cnt, m_cycles);
        end
      end
    end
  endtask

  initial begin
    rst = 0; rec_ready = 0; idle_inputs(); model_clear();
    test_reset();
    test_single();
    test_fill();
    test_full_push_pop();
    test_halt();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
